// File: rtl/scr1_tb_ahb_arbiter_pkg.sv
// ============================================================================
//  Module      : scr1_tb_ahb_arbiter_pkg
//  Description : Shared AHB-Lite encodings and types for the IMEM/DMEM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scr1_tb_ahb_arbiter_pkg;

    localparam int c_ahb_width = 32;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IMEM = 2'd1,
        OWNER_DMEM = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        REQ_EMPTY  = 2'd0,
        REQ_WAIT   = 2'd1,
        REQ_ISSUED = 2'd2
    } req_state_e;

    // Masters here only ever issue single NONSEQ transfers.
    function automatic logic htrans_illegal(input logic [1:0] htrans);
        return (htrans == c_htrans_seq) || (htrans == c_htrans_busy);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scr1_tb_ahb_arb_req.sv
// ============================================================================
//  Module      : scr1_tb_ahb_arb_req
//  Description : One-deep AHB request register with EMPTY/WAIT/ISSUED tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_tb_ahb_arb_req
    import scr1_tb_ahb_arbiter_pkg::*;
#(
    parameter int AHB_W = c_ahb_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       htrans,
    input  logic [AHB_W-1:0] haddr,
    input  logic [2:0]       hsize,
    input  logic             hwrite,
    output logic             hready,
    output logic             hresp,
    input  logic             mem_hready,
    input  logic             mem_hresp,
    input  logic             issue,
    output logic             pending,
    output logic [AHB_W-1:0] req_addr,
    output logic [2:0]       req_size,
    output logic             req_write
);

    req_state_e       r_state;
    req_state_e       w_state_next;
    logic             w_capture;
    logic [AHB_W-1:0] r_addr;
    logic [2:0]       r_size;
    logic             r_write;

    assign hready    = (r_state == REQ_EMPTY) || ((r_state == REQ_ISSUED) && mem_hready);
    assign hresp     = (r_state == REQ_ISSUED) ? mem_hresp : 1'b0;
    assign pending   = (r_state == REQ_WAIT);
    assign w_capture = hready && (htrans == c_htrans_nonseq);

    assign req_addr  = r_addr;
    assign req_size  = r_size;
    assign req_write = r_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            REQ_EMPTY: begin
                if (w_capture) begin
                    w_state_next = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (issue) begin
                    w_state_next = REQ_ISSUED;
                end
            end
            REQ_ISSUED: begin
                // A new NONSEQ in the completing cycle refills the slot directly.
                if (mem_hready) begin
                    w_state_next = w_capture ? REQ_WAIT : REQ_EMPTY;
                end
            end
            default: w_state_next = REQ_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
        end else if (w_capture) begin
            r_addr  <= haddr;
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

endmodule

`default_nettype wire

// File: rtl/scr1_tb_ahb_arbiter.sv
// ============================================================================
//  Module      : scr1_tb_ahb_arbiter
//  Description : Merges IMEM and DMEM AHB-Lite masters onto one AHB-Lite slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_tb_ahb_arbiter
    import scr1_tb_ahb_arbiter_pkg::*;
#(
    parameter int AHB_W    = c_ahb_width,
    parameter int ARB_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       imem_htrans,
    input  logic [AHB_W-1:0] imem_haddr,
    input  logic [2:0]       imem_hsize,
    output logic             imem_hready,
    output logic [AHB_W-1:0] imem_hrdata,
    output logic             imem_hresp,
    input  logic [1:0]       dmem_htrans,
    input  logic [AHB_W-1:0] dmem_haddr,
    input  logic [2:0]       dmem_hsize,
    input  logic             dmem_hwrite,
    input  logic [AHB_W-1:0] dmem_hwdata,
    output logic             dmem_hready,
    output logic [AHB_W-1:0] dmem_hrdata,
    output logic             dmem_hresp,
    output logic [1:0]       mem_htrans,
    output logic [AHB_W-1:0] mem_haddr,
    output logic [2:0]       mem_hsize,
    output logic             mem_hwrite,
    output logic [AHB_W-1:0] mem_hwdata,
    input  logic             mem_hready,
    input  logic [AHB_W-1:0] mem_hrdata,
    input  logic             mem_hresp,
    output logic             proto_err
);

    logic             w_imem_pending;
    logic             w_dmem_pending;
    logic             w_imem_issue;
    logic             w_dmem_issue;
    logic             w_grant_imem;
    logic             w_grant_dmem;
    logic             w_any_pending;
    logic [AHB_W-1:0] w_imem_addr;
    logic [AHB_W-1:0] w_dmem_addr;
    logic [2:0]       w_imem_size;
    logic [2:0]       w_dmem_size;
    logic             w_imem_write;
    logic             w_dmem_write;

    owner_e r_owner;
    owner_e r_turn;
    logic   r_proto_err;

    scr1_tb_ahb_arb_req #(
        .AHB_W (AHB_W)
    ) u_imem_req (
        .clk        (clk),
        .rst        (rst),
        .htrans     (imem_htrans),
        .haddr      (imem_haddr),
        .hsize      (imem_hsize),
        .hwrite     (1'b0),
        .hready     (imem_hready),
        .hresp      (imem_hresp),
        .mem_hready (mem_hready),
        .mem_hresp  (mem_hresp),
        .issue      (w_imem_issue),
        .pending    (w_imem_pending),
        .req_addr   (w_imem_addr),
        .req_size   (w_imem_size),
        .req_write  (w_imem_write)
    );

    scr1_tb_ahb_arb_req #(
        .AHB_W (AHB_W)
    ) u_dmem_req (
        .clk        (clk),
        .rst        (rst),
        .htrans     (dmem_htrans),
        .haddr      (dmem_haddr),
        .hsize      (dmem_hsize),
        .hwrite     (dmem_hwrite),
        .hready     (dmem_hready),
        .hresp      (dmem_hresp),
        .mem_hready (mem_hready),
        .mem_hresp  (mem_hresp),
        .issue      (w_dmem_issue),
        .pending    (w_dmem_pending),
        .req_addr   (w_dmem_addr),
        .req_size   (w_dmem_size),
        .req_write  (w_dmem_write)
    );

    generate
        if (ARB_MODE == 1) begin : g_fixed_prio
            assign w_grant_dmem = w_dmem_pending;
        end else begin : g_round_robin
            // r_turn names the master that wins the next tie; IMEM holds it after reset.
            assign w_grant_dmem = w_dmem_pending && (!w_imem_pending || (r_turn == OWNER_DMEM));
        end
    endgenerate

    assign w_grant_imem  = w_imem_pending && !w_grant_dmem;
    assign w_any_pending = w_imem_pending || w_dmem_pending;
    assign w_imem_issue  = mem_hready && w_grant_imem;
    assign w_dmem_issue  = mem_hready && w_grant_dmem;

    always_comb begin
        mem_htrans = c_htrans_idle;
        mem_haddr  = '0;
        mem_hsize  = '0;
        mem_hwrite = 1'b0;
        if (w_grant_dmem) begin
            mem_htrans = c_htrans_nonseq;
            mem_haddr  = w_dmem_addr;
            mem_hsize  = w_dmem_size;
            mem_hwrite = w_dmem_write;
        end else if (w_grant_imem) begin
            mem_htrans = c_htrans_nonseq;
            mem_haddr  = w_imem_addr;
            mem_hsize  = w_imem_size;
            mem_hwrite = w_imem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWNER_NONE;
            r_turn  <= OWNER_IMEM;
        end else if (mem_hready) begin
            if (w_grant_dmem) begin
                r_owner <= OWNER_DMEM;
                r_turn  <= OWNER_IMEM;
            end else if (w_grant_imem) begin
                r_owner <= OWNER_IMEM;
                r_turn  <= OWNER_DMEM;
            end else begin
                r_owner <= OWNER_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (htrans_illegal(imem_htrans) || htrans_illegal(dmem_htrans)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err   = r_proto_err;
    assign mem_hwdata  = (r_owner == OWNER_DMEM) ? dmem_hwdata : '0;
    assign imem_hrdata = mem_hrdata;
    assign dmem_hrdata = mem_hrdata;

endmodule

`default_nettype wire

// File: tb/tb_scr1_tb_ahb_arbiter.sv
// ============================================================================
//  Module      : tb_scr1_tb_ahb_arbiter
//  Description : Directed vector bench for the IMEM/DMEM AHB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scr1_tb_ahb_arbiter;

    localparam logic [1:0]  I  = 2'b00;
    localparam logic [1:0]  N  = 2'b10;
    localparam logic [1:0]  S  = 2'b11;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam int          NV = 40;

    typedef struct {
        logic        r;
        logic [1:0]  it;
        logic [31:0] ia;
        logic [1:0]  dt;
        logic [31:0] da;
        logic        dw;
        logic [31:0] dwd;
        logic        mr;
        logic        me;
        logic [1:0]  xmt;
        logic [31:0] xma;
        logic        xmw;
        logic [31:0] xmwd;
        logic        xir;
        logic        xie;
        logic        xdr;
        logic        xde;
        logic        xpe;
        logic [31:0] xrd;
        logic        c1;
        logic [31:0] xma1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  imem_htrans;
    logic [31:0] imem_haddr;
    logic [2:0]  imem_hsize;
    logic        imem_hready;
    logic [31:0] imem_hrdata;
    logic        imem_hresp;
    logic [1:0]  dmem_htrans;
    logic [31:0] dmem_haddr;
    logic [2:0]  dmem_hsize;
    logic        dmem_hwrite;
    logic [31:0] dmem_hwdata;
    logic        dmem_hready;
    logic [31:0] dmem_hrdata;
    logic        dmem_hresp;
    logic [1:0]  mem_htrans;
    logic [31:0] mem_haddr;
    logic [2:0]  mem_hsize;
    logic        mem_hwrite;
    logic [31:0] mem_hwdata;
    logic        mem_hready;
    logic [31:0] mem_hrdata;
    logic        mem_hresp;
    logic        proto_err;

    logic        f_imem_hready, f_imem_hresp, f_dmem_hready, f_dmem_hresp;
    logic [31:0] f_imem_hrdata, f_dmem_hrdata, f_mem_haddr, f_mem_hwdata;
    logic [1:0]  f_mem_htrans;
    logic [2:0]  f_mem_hsize;
    logic        f_mem_hwrite, f_proto_err;
    logic [31:0] f_mem_hrdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scr1_tb_ahb_arbiter #(.AHB_W(32), .ARB_MODE(0)) dut (
        .clk (clk), .rst (rst),
        .imem_htrans (imem_htrans), .imem_haddr (imem_haddr), .imem_hsize (imem_hsize),
        .imem_hready (imem_hready), .imem_hrdata (imem_hrdata), .imem_hresp (imem_hresp),
        .dmem_htrans (dmem_htrans), .dmem_haddr (dmem_haddr), .dmem_hsize (dmem_hsize),
        .dmem_hwrite (dmem_hwrite), .dmem_hwdata (dmem_hwdata), .dmem_hready (dmem_hready),
        .dmem_hrdata (dmem_hrdata), .dmem_hresp (dmem_hresp),
        .mem_htrans (mem_htrans), .mem_haddr (mem_haddr), .mem_hsize (mem_hsize),
        .mem_hwrite (mem_hwrite), .mem_hwdata (mem_hwdata), .mem_hready (mem_hready),
        .mem_hrdata (mem_hrdata), .mem_hresp (mem_hresp), .proto_err (proto_err)
    );

    scr1_tb_ahb_arbiter #(.AHB_W(32), .ARB_MODE(1)) dut_fixed (
        .clk (clk), .rst (rst),
        .imem_htrans (imem_htrans), .imem_haddr (imem_haddr), .imem_hsize (imem_hsize),
        .imem_hready (f_imem_hready), .imem_hrdata (f_imem_hrdata), .imem_hresp (f_imem_hresp),
        .dmem_htrans (dmem_htrans), .dmem_haddr (dmem_haddr), .dmem_hsize (dmem_hsize),
        .dmem_hwrite (dmem_hwrite), .dmem_hwdata (dmem_hwdata), .dmem_hready (f_dmem_hready),
        .dmem_hrdata (f_dmem_hrdata), .dmem_hresp (f_dmem_hresp),
        .mem_htrans (f_mem_htrans), .mem_haddr (f_mem_haddr), .mem_hsize (f_mem_hsize),
        .mem_hwrite (f_mem_hwrite), .mem_hwdata (f_mem_hwdata), .mem_hready (mem_hready),
        .mem_hrdata (f_mem_hrdata), .mem_hresp (mem_hresp), .proto_err (f_proto_err)
    );

    // Slave model: word i reads as 0x1000_0000 + i unless written; one write slot is enough here.
    logic        dp_valid, dp_write;
    logic [11:0] dp_idx;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_idx   = 12'h0;
    logic [31:0] wr_data  = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= 12'h0;
        end else if (mem_hready) begin
            if (dp_valid && dp_write) begin
                wr_valid <= 1'b1;
                wr_idx   <= dp_idx;
                wr_data  <= mem_hwdata;
            end
            dp_valid <= (mem_htrans == N);
            dp_write <= mem_hwrite;
            dp_idx   <= mem_haddr[13:2];
        end
    end

    always_comb begin
        mem_hrdata = 32'h0;
        if (dp_valid && !dp_write) begin
            mem_hrdata = (wr_valid && wr_idx == dp_idx) ? wr_data : (32'h1000_0000 | {20'h0, dp_idx});
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic [1:0] it, input logic [31:0] ia,
        input logic [1:0] dt, input logic [31:0] da, input logic dw, input logic [31:0] dwd,
        input logic mr, input logic me,
        input logic [1:0] xmt, input logic [31:0] xma, input logic xmw, input logic [31:0] xmwd,
        input logic xir, input logic xie, input logic xdr, input logic xde, input logic xpe,
        input logic [31:0] xrd, input logic c1, input logic [31:0] xma1);
        vec_t v;
        v.r = r; v.it = it; v.ia = ia; v.dt = dt; v.da = da; v.dw = dw; v.dwd = dwd;
        v.mr = mr; v.me = me; v.xmt = xmt; v.xma = xma; v.xmw = xmw; v.xmwd = xmwd;
        v.xir = xir; v.xie = xie; v.xdr = xdr; v.xde = xde; v.xpe = xpe; v.xrd = xrd;
        v.c1 = c1; v.xma1 = xma1;
        return v;
    endfunction

    vec_t vt [NV];
    int   lat;

    initial begin
        //            r  it  ia       dt  da        dw dwd mr me | mt  ma       mw mwd ir ie dr de pe rd           c1 ma1
        vt[0]  = mk(1, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[1]  = mk(0, N, 'h200,   I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[2]  = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h200,    0, 0,  0, 0, 1, 0, 0, 0,            0, 0);
        vt[3]  = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h10000080,   0, 0);
        vt[4]  = mk(1, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[5]  = mk(0, N, 'h204,   N, 'h300,    0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[6]  = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h204,    0, 0,  0, 0, 0, 0, 0, 0,            1, 'h300);
        vt[7]  = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h300,    0, 0,  1, 0, 0, 0, 0, 'h10000081,   1, 'h204);
        vt[8]  = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h100000C0,   0, 0);
        vt[9]  = mk(0, I, 0,       N, 'h1000,   1, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[10] = mk(0, I, 0,       I, 0,        0, DB, 1, 0,   N, 'h1000,   1, 0,  1, 0, 0, 0, 0, 0,            0, 0);
        vt[11] = mk(0, I, 0,       I, 0,        0, DB, 0, 0,   I, 0,        0, DB, 1, 0, 0, 0, 0, 0,            0, 0);
        vt[12] = mk(0, I, 0,       I, 0,        0, DB, 0, 0,   I, 0,        0, DB, 1, 0, 0, 0, 0, 0,            0, 0);
        vt[13] = mk(0, I, 0,       I, 0,        0, DB, 0, 0,   I, 0,        0, DB, 1, 0, 0, 0, 0, 0,            0, 0);
        vt[14] = mk(0, I, 0,       I, 0,        0, DB, 1, 0,   I, 0,        0, DB, 1, 0, 1, 0, 0, 0,            0, 0);
        vt[15] = mk(0, I, 0,       N, 'h1000,   0, DB, 1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[16] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h1000,   0, 0,  1, 0, 0, 0, 0, 0,            0, 0);
        vt[17] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, DB,           0, 0);
        vt[18] = mk(0, I, 0,       N, 'h300,    0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[19] = mk(0, N, 'h208,   I, 0,        0, 0,  1, 0,   N, 'h300,    0, 0,  1, 0, 0, 0, 0, 0,            0, 0);
        vt[20] = mk(0, I, 0,       I, 0,        0, 0,  0, 1,   N, 'h208,    0, 0,  0, 0, 0, 1, 0, 'h100000C0,   0, 0);
        vt[21] = mk(0, I, 0,       I, 0,        0, 0,  1, 1,   N, 'h208,    0, 0,  0, 0, 1, 1, 0, 'h100000C0,   0, 0);
        vt[22] = mk(0, I, 0,       N, 'h304,    0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h10000082,   0, 0);
        vt[23] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h304,    0, 0,  1, 0, 0, 0, 0, 0,            0, 0);
        vt[24] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h100000C1,   0, 0);
        vt[25] = mk(0, I, 0,       N, 'h308,    0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[26] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h308,    0, 0,  1, 0, 0, 0, 0, 0,            0, 0);
        vt[27] = mk(1, I, 0,       I, 0,        0, 0,  0, 0,   I, 0,        0, 0,  1, 0, 0, 0, 0, 'h100000C2,   0, 0);
        vt[28] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[29] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[30] = mk(0, S, 'h400,   I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[31] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 1, 0,            0, 0);
        vt[32] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 1, 0,            0, 0);
        vt[33] = mk(1, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 1, 0,            0, 0);
        vt[34] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[35] = mk(0, N, 'h20C,   I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 0,            0, 0);
        vt[36] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h20C,    0, 0,  0, 0, 1, 0, 0, 0,            0, 0);
        vt[37] = mk(0, N, 'h210,   I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h10000083,   0, 0);
        vt[38] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   N, 'h210,    0, 0,  0, 0, 1, 0, 0, 0,            0, 0);
        vt[39] = mk(0, I, 0,       I, 0,        0, 0,  1, 0,   I, 0,        0, 0,  1, 0, 1, 0, 0, 'h10000084,   0, 0);

        rst = 1'b1;
        imem_htrans = I; imem_haddr = '0; imem_hsize = 3'd2;
        dmem_htrans = I; dmem_haddr = '0; dmem_hsize = 3'd2; dmem_hwrite = 1'b0; dmem_hwdata = '0;
        mem_hready = 1'b1; mem_hresp = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < NV; k++) begin
            @(posedge clk);
            #1;
            rst         = vt[k].r;
            imem_htrans = vt[k].it;
            imem_haddr  = vt[k].ia;
            dmem_htrans = vt[k].dt;
            dmem_haddr  = vt[k].da;
            dmem_hwrite = vt[k].dw;
            dmem_hwdata = vt[k].dwd;
            mem_hready  = vt[k].mr;
            mem_hresp   = vt[k].me;
            @(negedge clk);
            check("mem_htrans",  k, {30'h0, mem_htrans}, {30'h0, vt[k].xmt});
            check("mem_haddr",   k, mem_haddr,            vt[k].xma);
            check("mem_hwrite",  k, {31'h0, mem_hwrite},  {31'h0, vt[k].xmw});
            check("mem_hwdata",  k, mem_hwdata,           vt[k].xmwd);
            check("imem_hready", k, {31'h0, imem_hready}, {31'h0, vt[k].xir});
            check("imem_hresp",  k, {31'h0, imem_hresp},  {31'h0, vt[k].xie});
            check("dmem_hready", k, {31'h0, dmem_hready}, {31'h0, vt[k].xdr});
            check("dmem_hresp",  k, {31'h0, dmem_hresp},  {31'h0, vt[k].xde});
            check("proto_err",   k, {31'h0, proto_err},   {31'h0, vt[k].xpe});
            check("imem_hrdata", k, imem_hrdata,          vt[k].xrd);
            check("dmem_hrdata", k, dmem_hrdata,          vt[k].xrd);
            if (vt[k].c1) begin
                check("fixed_htrans", k, {30'h0, f_mem_htrans}, {30'h0, N});
                check("fixed_haddr",  k, f_mem_haddr,           vt[k].xma1);
            end
        end

        // Lone fetch latency measured with a bounded wait for imem_hready.
        @(posedge clk);
        #1;
        imem_htrans = N;
        imem_haddr  = 32'h214;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            imem_htrans = I;
            @(negedge clk);
            if (imem_hready) begin
                lat = c;
                break;
            end
        end
        check("fetch_latency", NV, lat, 2);
        check("fetch_rdata",   NV, imem_hrdata, 32'h10000085);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
